instr_mem_loadable: RTL

//  Parametrised instruction memory for the multi-cycle CPU. Adds a program-load

---
 rtl/instr_mem_loadable.sv | 100 ++++++++++
 1 files changed

// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: program-load port, IDLE/LOAD/RUN/HALT controller,
// registered fetch with valid strobe, sticky out-of-range fault and fetch counter.
module instr_mem_loadable #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 14,
  parameter logic [2:0]        IF_CODE  = 3'd0,
  parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_start,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  input  logic              prog_done,
  input  logic [2:0]        cpu_state,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] instr,
  output logic              instr_valid,
  output logic              fetch_fault,
  output logic              ready,
  output logic [15:0]       fetch_cnt
);

  localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   DEPTH_W = (ADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, HALT} state_t;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   instr_reg;
  logic                valid_reg;
  logic                fault_reg;
  logic                ready_reg;
  logic [15:0]         cnt_reg;

  logic                fetch_req;
  logic                pc_in_range;
  logic                prog_in_range;

  always_comb begin
    state_next    = state_reg;
    fetch_req     = (state_reg == RUN) && (cpu_state == IF_CODE);
    pc_in_range   = {1'b0, pc} < DEPTH_W;
    prog_in_range = {1'b0, prog_addr} < DEPTH_W;
    case (state_reg)
      IDLE: if (prog_start) state_next = LOAD;
      LOAD: begin
        if (prog_start)     state_next = LOAD;
        else if (prog_done) state_next = RUN;
      end
      RUN: begin
        if (prog_start)                     state_next = LOAD;
        else if (fetch_req && !pc_in_range) state_next = HALT;
      end
      HALT: if (prog_start) state_next = LOAD;
      default: state_next = IDLE;
    endcase
  end

  // Memory contents deliberately survive reset so a reset mid-load keeps written words.
  always_ff @(posedge clk) begin
    if (state_reg == LOAD && prog_we && prog_in_range)
      mem[prog_addr[IDX_W-1:0]] <= prog_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      instr_reg <= '0;
      valid_reg <= 1'b0;
      fault_reg <= 1'b0;
      ready_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ready_reg <= (state_next == RUN);
      valid_reg <= fetch_req;
      if (fetch_req)
        instr_reg <= pc_in_range ? mem[pc[IDX_W-1:0]] : NOP_WORD;
      // Re-entering LOAD wins over any fetch bookkeeping in the same cycle.
      if (prog_start) begin
        fault_reg <= 1'b0;
        cnt_reg   <= '0;
      end else if (fetch_req) begin
        if (!pc_in_range)             fault_reg <= 1'b1;
        else if (cnt_reg != 16'hFFFF) cnt_reg   <= cnt_reg + 16'd1;
      end
    end
  end

  assign instr       = instr_reg;
  assign instr_valid = valid_reg;
  assign fetch_fault = fault_reg;
  assign ready       = ready_reg;
  assign fetch_cnt   = cnt_reg;

endmodule
